bram_port_arbiter: RTL
======================

# bram_port_arbiter

Single-clock arbiter sharing one simple dual-port 16-bit BRAM (write port A, read port B) between two write requesters and two read requesters in the transpose-convolution datapath. Each port has an independent round-robin arbiter with valid/ready handshakes. BRAM control signals are registered, and read responses are returned with a fixed latency, tagged back to the originating requester.

## Interface
- DATA_WIDTH, 16: BRAM word width (signed fixed-point).
- ADDR_WIDTH, 10: BRAM address width (depth 2^ADDR_WIDTH).
- clk  in  1  single clock for both BRAM ports and all logic.
- rst_n  in  1  asynchronous, active-low reset.
- wr0_valid / wr1_valid  in  1  write request.
- wr0_ready / wr1_ready  out  1  write grant; handshake when valid&&ready.
- wr0_addr / wr1_addr  in  ADDR_WIDTH  write address.
- wr0_data / wr1_data  in  DATA_WIDTH  write data.
- rd0_valid / rd1_valid  in  1  read request.
- rd0_ready / rd1_ready  out  1  read grant.
- rd0_addr / rd1_addr  in  ADDR_WIDTH  read address.
- rd0_rsp_valid / rd1_rsp_valid  out  1  one-cycle read-data strobe.
- rd_rsp_data  out  DATA_WIDTH  read data, shared; qualified by rdX_rsp_valid.
- bram_ena, bram_wea  out  1  BRAM port A enable/write enable (driven identically).
- bram_addra  out  ADDR_WIDTH; bram_dia  out  DATA_WIDTH.
- bram_enb  out  1; bram_addrb  out  ADDR_WIDTH.
- bram_dob  in  DATA_WIDTH  BRAM registered read data.

## Operation
- Port A and port B are arbitrated independently; both can be granted in the same cycle.
- Arbitration per port is 2-way round-robin, using a 1-bit priority pointer per port (reset 0 = requester 0 preferred).
- readyX is combinational from the valids and the pointer:
  - If only one requester is valid, it is granted.
  - If both are valid, the pointer's requester is granted.
  - At most one ready per port is high.
- On each handshake the pointer moves to the non-granted requester. The pointer is unchanged when no handshake occurs.
- readyX is never asserted while validX is low.
- Write handshake registers addr/data into bram_addra/bram_dia and asserts bram_ena=bram_wea=1 for exactly the next cycle.
- Read handshake registers addr into bram_addrb, asserts bram_enb for the next cycle, and pushes requester ID into a 2-stage tag pipeline.
- rd_rsp_data is bram_dob passed through combinationally. rdX_rsp_valid comes from tag stage 2.
- No response backpressure; requesters must sink responses.
- Address arithmetic: none; addresses pass unmodified, and full ADDR_WIDTH wraps naturally.

## Timing
- Reset values:
  - All readys low while rst_n is low.
  - bram_ena, bram_wea, bram_enb = 0; bram_addra, bram_addrb, bram_dia = 0.
  - Both rsp_valids = 0; tag pipeline cleared; both pointers = 0.
- Write: handshake in cycle T, BRAM enables high in T+1, memory updated at the end of T+1.
- Read: handshake in cycle T, bram_enb in T+1, rdX_rsp_valid and data in T+2. Latency is 2; sustained throughput is 1 read per cycle.
- Read/write same address:
  - Read accepted in the same cycle as the write: returns the old word (read-first).
  - Read accepted at T+1 or later: returns the new word.
  - No forwarding is performed.
- Simultaneous valid from both requesters on a port every cycle: grants alternate 0,1,0,1,… starting from the pointer.
- Reset asserted mid-operation: in-flight reads are discarded with no rsp_valid; a pending registered write is dropped (bram_ena forced 0 asynchronously).
- No combinational path from rsp to ready; BRAM outputs are registered.

## Structure
- Shared package bram_arb_pkg holds:
  - DATA_WIDTH/ADDR_WIDTH defaults.
  - Requester ID localparams REQ0=1'b0, REQ1=1'b1.
  - Tag pipeline depth localparam RD_LATENCY=2.
- Sub-module rr_arbiter_2 (valid[1:0] in, ready[1:0] out, pointer register inside, async active-low reset), instantiated once per port.
- Top holds the BRAM control registers and the read tag pipeline.

## Test plan
- Reset, then idle: all outputs 0. Then rd0 at addr 5 after wr0 (addr 5, 0x1234) accepted one cycle earlier → rd0_rsp_valid at T+2 with 0x1234, rd1_rsp_valid stays 0.
- wr0 and wr1 both valid for 4 cycles (addrs 1,2 / 3,4) → grants 0,1,0,1. Memory then holds wr0 data at 1,2 and wr1 data at 3,4.
- Read and write to addr 7 (old 0x0001, new 0x00FF) accepted the same cycle → response 0x0001. A repeat read next cycle → 0x00FF.
- rd0 and rd1 valid back-to-back for 6 cycles on distinct preloaded addresses → one response per cycle, tags alternate, every data value matches its address.
- Reset pulse while 2 reads are in flight and 1 write is registered → no rsp_valid afterwards, target address unchanged, pointers back to 0.
- Only wr1 valid continuously for 3 cycles → wr1_ready high every cycle, wr0_ready never high.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared widths, requester IDs and read-tag payload for the BRAM port arbiter.
package bram_arb_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned DEF_ADDR_WIDTH = 10;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   localparam int unsigned RD_LATENCY = 2;

   // One stage of the read tag pipeline: occupancy plus originating requester
   typedef struct packed {
      logic valid;
      logic id;
   } rd_tag_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter with a one-bit priority pointer; ready is combinational.
module rr_arbiter_2
   import bram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   output logic [1:0] ready
);

   logic ptr_q;
   logic ptr_d;

   // Grant the lone requester, or the pointer's requester on contention
   always_comb begin
      ready = 2'b00;
      ptr_d = ptr_q;
      if (rst_n) begin
         case (valid)
            2'b01:   ready = 2'b01;
            2'b10:   ready = 2'b10;
            2'b11:   ready = (ptr_q == REQ1) ? 2'b10 : 2'b01;
            default: ready = 2'b00;
         endcase
         if (ready[0]) begin
            ptr_d = REQ1;
         end else if (ready[1]) begin
            ptr_d = REQ0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= REQ0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one simple dual-port BRAM between two writers (port A) and two readers (port B),
// registering BRAM controls and returning tagged read data after a fixed latency.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr0_valid,
   output logic                  wr0_ready,
   input  logic [ADDR_WIDTH-1:0] wr0_addr,
   input  logic [DATA_WIDTH-1:0] wr0_data,
   input  logic                  wr1_valid,
   output logic                  wr1_ready,
   input  logic [ADDR_WIDTH-1:0] wr1_addr,
   input  logic [DATA_WIDTH-1:0] wr1_data,
   input  logic                  rd0_valid,
   output logic                  rd0_ready,
   input  logic [ADDR_WIDTH-1:0] rd0_addr,
   input  logic                  rd1_valid,
   output logic                  rd1_ready,
   input  logic [ADDR_WIDTH-1:0] rd1_addr,
   output logic                  rd0_rsp_valid,
   output logic                  rd1_rsp_valid,
   output logic [DATA_WIDTH-1:0] rd_rsp_data,
   output logic                  bram_ena,
   output logic                  bram_wea,
   output logic [ADDR_WIDTH-1:0] bram_addra,
   output logic [DATA_WIDTH-1:0] bram_dia,
   output logic                  bram_enb,
   output logic [ADDR_WIDTH-1:0] bram_addrb,
   input  logic [DATA_WIDTH-1:0] bram_dob
);

   logic [1:0] wr_ready;
   logic [1:0] rd_ready;
   logic       wr_hs;
   logic       rd_hs;
   logic       wr_sel;
   logic       rd_sel;
   rd_tag_t    tag_q [RD_LATENCY];

   rr_arbiter_2 u_wr_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .valid ({wr1_valid, wr0_valid}),
      .ready (wr_ready)
   );

   rr_arbiter_2 u_rd_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .valid ({rd1_valid, rd0_valid}),
      .ready (rd_ready)
   );

   assign wr0_ready = wr_ready[0];
   assign wr1_ready = wr_ready[1];
   assign rd0_ready = rd_ready[0];
   assign rd1_ready = rd_ready[1];

   assign wr_hs  = |(wr_ready & {wr1_valid, wr0_valid});
   assign rd_hs  = |(rd_ready & {rd1_valid, rd0_valid});
   assign wr_sel = wr_ready[1] ? REQ1 : REQ0;
   assign rd_sel = rd_ready[1] ? REQ1 : REQ0;

   // Port A: one-cycle write strobe; address/data held until the next handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bram_ena   <= 1'b0;
         bram_addra <= '0;
         bram_dia   <= '0;
      end else begin
         bram_ena <= wr_hs;
         if (wr_hs) begin
            bram_addra <= (wr_sel == REQ1) ? wr1_addr : wr0_addr;
            bram_dia   <= (wr_sel == REQ1) ? wr1_data : wr0_data;
         end
      end
   end

   assign bram_wea = bram_ena;

   // Port B: read strobe plus requester tag tracking the BRAM output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bram_enb   <= 1'b0;
         bram_addrb <= '0;
         for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         bram_enb <= rd_hs;
         if (rd_hs) begin
            bram_addrb <= (rd_sel == REQ1) ? rd1_addr : rd0_addr;
         end
         tag_q[0] <= '{valid: rd_hs, id: rd_sel};
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign rd0_rsp_valid = tag_q[RD_LATENCY-1].valid && (tag_q[RD_LATENCY-1].id == REQ0);
   assign rd1_rsp_valid = tag_q[RD_LATENCY-1].valid && (tag_q[RD_LATENCY-1].id == REQ1);
   assign rd_rsp_data   = bram_dob;

endmodule
